// File: rtl/rfs_pio_pkg.sv
// ============================================================================
// Module      : rfs_pio_pkg
// Description : Shared constants for the pulse-capable output PIO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rfs_pio_pkg;

    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_SET       = 3'd1;
    localparam logic [2:0] ADDR_CLEAR     = 3'd2;
    localparam logic [2:0] ADDR_PULSE_LEN = 3'd3;
    localparam logic [2:0] ADDR_PULSE     = 3'd4;
    localparam logic [2:0] ADDR_STATUS    = 3'd5;

    localparam int                 STATE_W   = 1;
    localparam logic [STATE_W-1:0] ST_IDLE   = 1'b0;
    localparam logic [STATE_W-1:0] ST_ACTIVE = 1'b1;

    localparam int STAT_BUSY_BIT    = 0;
    localparam int STAT_OVERRUN_BIT = 1;

endpackage

`default_nettype wire

// File: rtl/rfs_pulse_timer.sv
// ============================================================================
// Module      : rfs_pulse_timer
// Description : Down-counter that keeps busy high for exactly len cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rfs_pulse_timer
    import rfs_pio_pkg::*;
#(
    parameter int CNT_W     = 24,
    parameter int PULSE_DEF = 1000,
    parameter bit POR_EN    = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    output logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             done
);

    localparam logic [STATE_W-1:0] c_RST_STATE = POR_EN ? ST_ACTIVE : ST_IDLE;
    localparam logic [CNT_W-1:0]   c_RST_CNT   = POR_EN ? CNT_W'(PULSE_DEF) : '0;

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_RST_STATE;
            r_cnt   <= c_RST_CNT;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load) begin
                    w_state_nxt = ST_ACTIVE;
                    w_cnt_nxt   = len;
                end
            end
            ST_ACTIVE: begin
                // Last inverted cycle: count reaches zero together with the state change.
                if (r_cnt == CNT_W'(1)) begin
                    done        = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign cnt  = r_cnt;
    assign busy = (r_state == ST_ACTIVE);

endmodule

`default_nettype wire

// File: rtl/rfs_pio_pulse_out.sv
// ============================================================================
// Module      : rfs_pio_pulse_out
// Description : Avalon-MM output PIO with set/clear and hardware-timed pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rfs_pio_pulse_out
    import rfs_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b1}},
    parameter int               CNT_W       = 24,
    parameter int               PULSE_DEF   = 1000,
    parameter logic [WIDTH-1:0] POR_MASK    = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             busy
);

    localparam bit c_POR_EN = (POR_MASK != '0);

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_mask;
    logic [CNT_W-1:0] r_len;
    logic             r_overrun;

    logic             w_wr;
    logic [WIDTH-1:0] w_wd;
    logic             w_pulse_wr;
    logic             w_start;
    logic             w_busy;
    logic             w_done;
    logic [CNT_W-1:0] w_cnt_unused;
    logic             w_unused_wd;

    assign w_wr        = chipselect & ~write_n;
    assign w_wd        = writedata[WIDTH-1:0];
    assign w_unused_wd = ^writedata;
    assign w_pulse_wr  = w_wr && (address == ADDR_PULSE);
    assign w_start     = w_pulse_wr && (w_wd != '0) && (r_len != '0) && !w_busy;

    rfs_pulse_timer #(
        .CNT_W     (CNT_W),
        .PULSE_DEF (PULSE_DEF),
        .POR_EN    (c_POR_EN)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (w_start),
        .len     (r_len),
        .cnt     (w_cnt_unused),
        .busy    (w_busy),
        .done    (w_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data    <= RESET_VALUE;
            r_len     <= CNT_W'(PULSE_DEF);
            r_overrun <= 1'b0;
            r_mask    <= POR_MASK;
        end else begin
            if (w_wr) begin
                case (address)
                    ADDR_DATA:      r_data <= w_wd;
                    ADDR_SET:       r_data <= r_data | w_wd;
                    ADDR_CLEAR:     r_data <= r_data & ~w_wd;
                    ADDR_PULSE_LEN: r_len  <= writedata[CNT_W-1:0];
                    default: ;
                endcase
            end
            // A pulse request while the timer runs (even on its last cycle) is dropped.
            if (w_pulse_wr && w_busy) begin
                r_overrun <= 1'b1;
            end else if (w_wr && (address == ADDR_STATUS) && writedata[STAT_OVERRUN_BIT]) begin
                r_overrun <= 1'b0;
            end
            if (w_start) begin
                r_mask <= w_wd;
            end else if (w_done) begin
                r_mask <= '0;
            end
        end
    end

    // Both operands are flops, so the pulse edges line up with busy.
    assign out_port = r_data ^ r_mask;
    assign busy     = w_busy;

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:      readdata[WIDTH-1:0] = r_data;
            ADDR_PULSE_LEN: readdata[CNT_W-1:0] = r_len;
            ADDR_PULSE:     readdata[WIDTH-1:0] = r_mask;
            ADDR_STATUS: begin
                readdata[STAT_BUSY_BIT]    = w_busy;
                readdata[STAT_OVERRUN_BIT] = r_overrun;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_rfs_pio_pulse_out.sv
// ============================================================================
// Module      : tb_rfs_pio_pulse_out
// Description : Directed self-checking bench for rfs_pio_pulse_out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rfs_pio_pulse_out;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        busy;

    logic        por_reset_n;
    logic [31:0] por_readdata;
    logic [7:0]  por_out_port;
    logic        por_busy;
    logic [2:0]  por_address;
    logic        por_chipselect;
    logic        por_write_n;
    logic [31:0] por_writedata;

    int n_checks;
    int n_fail;
    logic [31:0] rd;

    rfs_pio_pulse_out dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .busy       (busy)
    );

    rfs_pio_pulse_out #(
        .WIDTH       (8),
        .RESET_VALUE (8'hFF),
        .CNT_W       (24),
        .PULSE_DEF   (10),
        .POR_MASK    (8'h01)
    ) dut_por (
        .clk        (clk),
        .reset_n    (por_reset_n),
        .address    (por_address),
        .chipselect (por_chipselect),
        .write_n    (por_write_n),
        .writedata  (por_writedata),
        .readdata   (por_readdata),
        .out_port   (por_out_port),
        .busy       (por_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d          = readdata;
        chipselect = 1'b0;
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        reset_n        = 1'b0;
        por_reset_n    = 1'b0;
        address        = 3'd0;
        chipselect     = 1'b0;
        write_n        = 1'b1;
        writedata      = 32'h0;
        por_address    = 3'd0;
        por_chipselect = 1'b0;
        por_write_n    = 1'b1;
        por_writedata  = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;

        // 1: reset state
        check("rst_out", {24'h0, out_port}, 32'hFF);
        bus_read(3'd0, rd); check("rst_data", rd, 32'hFF);
        bus_read(3'd3, rd); check("rst_len", rd, 32'd1000);
        bus_read(3'd5, rd); check("rst_status", rd, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);

        // 2: direct write, set, clear
        bus_write(3'd0, 32'h30);
        bus_write(3'd1, 32'h0F);
        check("set_out", {24'h0, out_port}, 32'h3F);
        bus_write(3'd2, 32'h21);
        check("clr_out", {24'h0, out_port}, 32'h1E);
        bus_read(3'd0, rd); check("clr_data", rd, 32'h1E);
        bus_read(3'd1, rd); check("set_rd0", rd, 32'h0);
        bus_read(3'd2, rd); check("clr_rd0", rd, 32'h0);
        bus_read(3'd6, rd); check("addr6_rd0", rd, 32'h0);

        // 3+4: 5-cycle pulse on bit0 with an overrun attempt inside it
        bus_write(3'd0, 32'hFF);
        bus_write(3'd3, 32'd5);
        bus_write(3'd4, 32'h01);
        check("p_c1_out", {24'h0, out_port}, 32'hFE);
        check("p_c1_busy", {31'h0, busy}, 32'h1);
        bus_read(3'd4, rd); check("p_mask_rd", rd, 32'h01);
        bus_write(3'd4, 32'h02);
        check("p_c2_out", {24'h0, out_port}, 32'hFE);
        bus_read(3'd5, rd); check("ovr_status", rd, 32'h3);
        bus_write(3'd5, 32'h2);
        check("p_c3_out", {24'h0, out_port}, 32'hFE);
        bus_read(3'd5, rd); check("ovr_clr_status", rd, 32'h1);
        tick();
        check("p_c4_out", {24'h0, out_port}, 32'hFE);
        tick();
        check("p_c5_out", {24'h0, out_port}, 32'hFE);
        check("p_c5_busy", {31'h0, busy}, 32'h1);
        tick();
        check("p_end_out", {24'h0, out_port}, 32'hFF);
        check("p_end_busy", {31'h0, busy}, 32'h0);

        // 5: zero length is a no-op, then CLEAR during a 3-cycle pulse
        bus_write(3'd3, 32'd0);
        bus_write(3'd4, 32'h01);
        check("z_out", {24'h0, out_port}, 32'hFF);
        bus_read(3'd5, rd); check("z_status", rd, 32'h0);
        bus_write(3'd3, 32'd3);
        bus_write(3'd4, 32'h00);
        check("zm_busy", {31'h0, busy}, 32'h0);
        bus_write(3'd4, 32'h01);
        check("c_c1_out", {24'h0, out_port}, 32'hFE);
        bus_write(3'd2, 32'h80);
        check("c_c2_out", {24'h0, out_port}, 32'h7E);
        tick();
        check("c_c3_out", {24'h0, out_port}, 32'h7E);
        check("c_c3_busy", {31'h0, busy}, 32'h1);
        tick();
        check("c_end_out", {24'h0, out_port}, 32'h7F);
        check("c_end_busy", {31'h0, busy}, 32'h0);

        // 6: power-on pulse, aborted by reset at cycle 4, then a full 10-cycle run
        check("por_inrst_out", {24'h0, por_out_port}, 32'hFE);
        @(negedge clk);
        por_reset_n = 1'b1;
        #1;
        check("por_rel_busy", {31'h0, por_busy}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("por_a_out", {24'h0, por_out_port}, 32'hFE);
        end
        por_reset_n = 1'b0;
        #1;
        check("por_abort_out", {24'h0, por_out_port}, 32'hFE);
        tick();
        tick();
        check("por_held_out", {24'h0, por_out_port}, 32'hFE);
        @(negedge clk);
        por_reset_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("por_b_out", {24'h0, por_out_port}, 32'hFE);
        end
        check("por_b_busy", {31'h0, por_busy}, 32'h1);
        tick();
        check("por_end_out", {24'h0, por_out_port}, 32'hFF);
        check("por_end_busy", {31'h0, por_busy}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
